// File: rtl/pb_event_pkg.sv
// Shared types and helpers for the multi-channel pushbutton event block.
package pb_event_pkg;

  // Debounce state of one button channel.
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } pb_state_e;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 32'sd1;
  endfunction

endpackage

// File: rtl/pb_event_channel.sv
// One button channel: synchroniser, debounce FSM, long-press/auto-repeat
// timing and the per-channel event counter. All outputs are registered.
module pb_event_channel
  import pb_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 5000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int COUNT_W         = 8,
  parameter bit SATURATE        = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pb_raw,
  input  logic               clear,
  output logic               pb_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic               repeat_pulse,
  output logic [COUNT_W-1:0] count
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int RW = cnt_width((REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1);

  localparam logic [DW-1:0]      DEB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0]      DEB_ONE   = DW'(32'd1);
  localparam logic [HW-1:0]      HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]      HOLD_ONE  = HW'(32'd1);
  localparam logic [RW-1:0]      REP_LAST  = RW'((REPEAT_CYCLES > 0) ? (REPEAT_CYCLES - 1) : 0);
  localparam logic [RW-1:0]      REP_ONE   = RW'(32'd1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(32'd1);

  logic           sync1_r, sync2_r;
  pb_state_e      state_r, state_nxt_s;
  logic [DW-1:0]  stab_r, stab_nxt_s;
  logic [HW-1:0]  hold_r, hold_nxt_s;
  logic [RW-1:0]  rep_r, rep_nxt_s;
  logic           level_r, level_nxt_s;
  logic           press_r, press_nxt_s;
  logic           release_r, release_nxt_s;
  logic           long_r, long_nxt_s;
  logic           repeat_r, repeat_nxt_s;
  logic [COUNT_W-1:0] count_r;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pb_raw;
      sync2_r <= sync1_r;
    end
  end

  // Next-state, stability/hold counters and pulse decode for the debounce FSM.
  always_comb begin
    state_nxt_s   = state_r;
    stab_nxt_s    = stab_r;
    hold_nxt_s    = hold_r;
    rep_nxt_s     = rep_r;
    level_nxt_s   = level_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    repeat_nxt_s  = 1'b0;
    case (state_r)
      IDLE_LOW: begin
        if (sync2_r) begin
          state_nxt_s = WAIT_HIGH;
          stab_nxt_s  = DEB_ONE;
        end else begin
          stab_nxt_s  = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync2_r) begin
          state_nxt_s = IDLE_LOW;
          stab_nxt_s  = '0;
        end else if (stab_r == DEB_MAX) begin
          state_nxt_s = HELD_HIGH;
          stab_nxt_s  = '0;
          level_nxt_s = 1'b1;
          press_nxt_s = 1'b1;
          hold_nxt_s  = '0;
          rep_nxt_s   = '0;
        end else begin
          stab_nxt_s  = stab_r + DEB_ONE;
        end
      end
      HELD_HIGH: begin
        if (!sync2_r) begin
          // Hold timing freezes while the release is being qualified.
          state_nxt_s = WAIT_LOW;
          stab_nxt_s  = DEB_ONE;
        end else if (hold_r != HOLD_MAX) begin
          stab_nxt_s  = '0;
          hold_nxt_s  = hold_r + HOLD_ONE;
          long_nxt_s  = (hold_r == HOLD_LAST);
        end else if (REPEAT_CYCLES > 0) begin
          stab_nxt_s  = '0;
          if (rep_r == REP_LAST) begin
            rep_nxt_s    = '0;
            repeat_nxt_s = 1'b1;
          end else begin
            rep_nxt_s    = rep_r + REP_ONE;
          end
        end else begin
          // Repeat disabled: hold counter parks at its maximum.
          stab_nxt_s  = '0;
        end
      end
      WAIT_LOW: begin
        if (sync2_r) begin
          state_nxt_s   = HELD_HIGH;
          stab_nxt_s    = '0;
        end else if (stab_r == DEB_MAX) begin
          state_nxt_s   = IDLE_LOW;
          stab_nxt_s    = '0;
          level_nxt_s   = 1'b0;
          release_nxt_s = 1'b1;
          hold_nxt_s    = '0;
          rep_nxt_s     = '0;
        end else begin
          stab_nxt_s    = stab_r + DEB_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_LOW;
        stab_nxt_s  = '0;
        hold_nxt_s  = '0;
        rep_nxt_s   = '0;
        level_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE_LOW;
      stab_r    <= '0;
      hold_r    <= '0;
      rep_r     <= '0;
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      stab_r    <= stab_nxt_s;
      hold_r    <= hold_nxt_s;
      rep_r     <= rep_nxt_s;
      level_r   <= level_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
      repeat_r  <= repeat_nxt_s;
    end
  end

  // Event counter: clear wins over a press/repeat pulse; wrap or saturate at the top.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (press_r || repeat_r) begin
      if (count_r == CNT_MAX) begin
        count_r <= SATURATE ? CNT_MAX : '0;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign pb_level      = level_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign long_pulse    = long_r;
  assign repeat_pulse  = repeat_r;
  assign count         = count_r;

endmodule

// File: rtl/pb_multi_event_counter.sv
// Multi-channel pushbutton event counter: NUM_CH independent channels,
// counts packed into one flat bus for the display driver.
module pb_multi_event_counter
  import pb_event_pkg::*;
#(
  parameter int NUM_CH          = 3,
  parameter int DEBOUNCE_CYCLES = 5000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int COUNT_W         = 8,
  parameter bit SATURATE        = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         pb_raw,
  input  logic [NUM_CH-1:0]         clear,
  output logic [NUM_CH-1:0]         pb_level,
  output logic [NUM_CH-1:0]         press_pulse,
  output logic [NUM_CH-1:0]         release_pulse,
  output logic [NUM_CH-1:0]         long_pulse,
  output logic [NUM_CH-1:0]         repeat_pulse,
  output logic [NUM_CH*COUNT_W-1:0] counts
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pb_event_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .COUNT_W         (COUNT_W),
      .SATURATE        (SATURATE)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .pb_raw        (pb_raw[i]),
      .clear         (clear[i]),
      .pb_level      (pb_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .count         (counts[i*COUNT_W +: COUNT_W])
    );
  end

endmodule

// File: tb/tb_pb_multi_event_counter.sv
// Bench for pb_multi_event_counter: wrapping and saturating instances share
// stimulus; a run-length/elapsed-time model predicts every output each cycle.
module tb_pb_multi_event_counter;

  localparam int NCH  = 3;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int CW   = 4;

  logic clock = 1'b0;
  logic reset;
  logic [NCH-1:0] raw, clr;
  logic [NCH-1:0] lvl, prs, rel, lng, rpt;
  logic [NCH-1:0] lvl_s, prs_s, rel_s, lng_s, rpt_s;
  logic [NCH*CW-1:0] cnt, cnt_s;

  int checks = 0;
  int errors = 0;

  pb_multi_event_counter #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .COUNT_W(CW), .SATURATE(1'b0)) dut (
    .clock(clock), .reset(reset), .pb_raw(raw), .clear(clr),
    .pb_level(lvl), .press_pulse(prs), .release_pulse(rel),
    .long_pulse(lng), .repeat_pulse(rpt), .counts(cnt));

  pb_multi_event_counter #(.NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .COUNT_W(CW), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .pb_raw(raw), .clear(clr),
    .pb_level(lvl_s), .press_pulse(prs_s), .release_pulse(rel_s),
    .long_pulse(lng_s), .repeat_pulse(rpt_s), .counts(cnt_s));

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [NCH-1:0] m_s1, m_s2, m_lv, m_p, m_r, m_l, m_rp;
  int m_run[NCH], m_held[NCH], m_c0[NCH], m_c1[NCH];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lv = '0; m_p = '0; m_r = '0; m_l = '0; m_rp = '0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_held[c] = 0; m_c0[c] = 0; m_c1[c] = 0;
    end
  endtask

  // Level flips once a differing sample has been seen DEB+1 edges in a row;
  // held time counts edges spent stably high since the press.
  task automatic model_step();
    logic s;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      s = m_s2[c];
      if (clr[c]) begin
        m_c0[c] = 0; m_c1[c] = 0;
      end else if (m_p[c] || m_rp[c]) begin
        m_c0[c] = (m_c0[c] + 1) % (1 << CW);
        if (m_c1[c] < (1 << CW) - 1) m_c1[c] = m_c1[c] + 1;
      end
      m_p[c] = 1'b0; m_r[c] = 1'b0; m_l[c] = 1'b0; m_rp[c] = 1'b0;
      if (s != m_lv[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == DEB + 1) begin
          m_run[c] = 0; m_lv[c] = s; m_held[c] = 0;
          if (s) m_p[c] = 1'b1; else m_r[c] = 1'b1;
        end
      end else begin
        if (m_lv[c] && m_run[c] == 0) begin
          m_held[c] = m_held[c] + 1;
          m_l[c]  = (m_held[c] == HOLD);
          m_rp[c] = (REP > 0) && (m_held[c] > HOLD) && ((m_held[c] - HOLD) % REP == 0);
        end
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin : cmp
    logic [NCH*CW-1:0] e0, e1;
    for (int c = 0; c < NCH; c++) begin
      e0[c*CW +: CW] = CW'(m_c0[c]);
      e1[c*CW +: CW] = CW'(m_c1[c]);
    end
    chk("pb_level",      64'(lvl), 64'(m_lv));
    chk("press_pulse",   64'(prs), 64'(m_p));
    chk("release_pulse", 64'(rel), 64'(m_r));
    chk("long_pulse",    64'(lng), 64'(m_l));
    chk("repeat_pulse",  64'(rpt), 64'(m_rp));
    chk("counts_wrap",   64'(cnt), 64'(e0));
    chk("counts_sat",    64'(cnt_s), 64'(e1));
    chk("sat_pulses",    64'({lvl_s, prs_s, rel_s, lng_s, rpt_s}), 64'({m_lv, m_p, m_r, m_l, m_rp}));
  end

  // ---------------- stimulus helpers ----------------
  logic [NCH-1:0]    h_p[64], h_r[64], h_l[64], h_rp[64], h_lv[64];
  logic [NCH*CW-1:0] h_c0[64], h_c1[64];

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    raw = '0; clr = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive pat[e] on the masked channels at edge e; history index e = state after edge e.
  task automatic watch(input logic [NCH-1:0] mask, input logic [63:0] pat,
                       input int len, input int total, input int clr_edge);
    for (int e = 0; e < 64; e++) begin
      h_p[e] = '0; h_r[e] = '0; h_l[e] = '0; h_rp[e] = '0; h_lv[e] = '0;
      h_c0[e] = '0; h_c1[e] = '0;
    end
    for (int e = 0; e < total; e++) begin
      for (int c = 0; c < NCH; c++)
        if (mask[c]) raw[c] = (e < len) ? pat[e] : 1'b0;
      clr = (e == clr_edge) ? mask : '0;
      step();
      h_p[e] = prs; h_r[e] = rel; h_l[e] = lng; h_rp[e] = rpt; h_lv[e] = lvl;
      h_c0[e] = cnt; h_c1[e] = cnt_s;
    end
    clr = '0;
  endtask

  function automatic logic [63:0] emask(input int kind, input int c);
    logic [63:0] m;
    m = '0;
    for (int e = 0; e < 64; e++) begin
      case (kind)
        0: m[e] = h_p[e][c];
        1: m[e] = h_r[e][c];
        2: m[e] = h_l[e][c];
        3: m[e] = h_rp[e][c];
        default: m[e] = h_lv[e][c];
      endcase
    end
    return m;
  endfunction

  int rem[NCH];

  initial begin
    reset = 1'b0; raw = '0; clr = '0;
    model_reset();
    repeat (3) step();
    chk("reset_counts", 64'(cnt), 64'd0);
    chk("reset_level", 64'(lvl), 64'd0);
    reset = 1'b1;
    idle(4);

    // Clean press on ch0: high edges 0-11.
    watch(3'b001, 64'h0FFF, 12, 26, -1);
    chk("clean_press_edge", emask(0, 0), 64'd1 << 6);
    chk("clean_release_edge", emask(1, 0), 64'd1 << 18);
    chk("clean_level_window", emask(4, 0), 64'h3FFC0);
    chk("clean_count", 64'(h_c0[25][3:0]), 64'd1);
    idle(6);

    // Short glitch on ch1, then bounce-and-hold.
    watch(3'b010, 64'h7, 3, 15, -1);
    chk("glitch_press", emask(0, 1), 64'd0);
    chk("glitch_level", emask(4, 1), 64'd0);
    chk("glitch_count", 64'(h_c0[14][7:4]), 64'd0);
    watch(3'b010, 64'h1FFFF7, 21, 35, -1);
    chk("bounce_press_edge", emask(0, 1), 64'd1 << 10);
    chk("bounce_release_edge", emask(1, 1), 64'd1 << 27);
    chk("bounce_count", 64'(h_c0[34][7:4]), 64'd1);
    idle(6);

    // Long hold on ch2: high edges 0-44.
    watch(3'b100, 64'h1FFF_FFFF_FFFF, 45, 60, -1);
    chk("long_press_edge", emask(0, 2), 64'd1 << 6);
    chk("long_long_edge", emask(2, 2), 64'd1 << 26);
    chk("long_repeat_edges", emask(3, 2), (64'd1 << 34) | (64'd1 << 42));
    chk("long_release_edge", emask(1, 2), 64'd1 << 51);
    chk("long_count", 64'(h_c0[59][11:8]), 64'd3);
    idle(6);

    // 17 presses after a clear: wrap gives 1, saturate gives 15.
    clr = 3'b001; step(); clr = '0;
    for (int i = 0; i < 17; i++) watch(3'b001, 64'hFF, 8, 20, -1);
    chk("wrap_count", 64'(cnt[3:0]), 64'd1);
    chk("sat_count", 64'(cnt_s[3:0]), 64'd15);

    // Clear colliding with the 6th press pulse.
    clr = 3'b001; step(); clr = '0;
    for (int i = 0; i < 5; i++) watch(3'b001, 64'hFF, 8, 20, -1);
    watch(3'b001, 64'hFF, 8, 20, 7);
    chk("collide_before", 64'(h_c0[6][3:0]), 64'd5);
    chk("collide_press", emask(0, 0), 64'd1 << 6);
    chk("collide_after", 64'(h_c0[7][3:0]), 64'd0);
    chk("collide_end", 64'(h_c0[19][3:0]), 64'd0);
    idle(6);

    // Asynchronous reset during a held ch0, then simultaneous presses.
    watch(3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64, 30, -1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_level", 64'(lvl), 64'd0);
    chk("async_counts", 64'(cnt), 64'd0);
    chk("async_counts_sat", 64'(cnt_s), 64'd0);
    chk("async_pulses", 64'({prs, rel, lng, rpt}), 64'd0);
    step();
    reset = 1'b1;
    watch(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64, 20, -1);
    chk("rst_press_ch0", emask(0, 0), 64'd1 << 6);
    chk("rst_press_ch1", emask(0, 1), 64'd1 << 6);
    chk("rst_press_ch2", emask(0, 2), 64'd1 << 6);
    chk("rst_counts", 64'(h_c0[19]), 64'h111);
    idle(10);

    // Randomised bursts: mostly short glitches, some long holds, rare clears.
    for (int c = 0; c < NCH; c++) rem[c] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if (rem[c] == 0) begin
          raw[c] = ~raw[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 7);
        end else begin
          rem[c] = rem[c] - 1;
        end
        clr[c] = ($urandom_range(0, 63) == 0);
      end
      step();
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_multi_event_counter.md
Name: pb_multi_event_counter

Overview:
- Parametrised, multi-channel successor to the fixed three-debouncer/three-counter arrangement.
- Per channel: 2-FF synchroniser, debounce FSM, press/release edge pulses, long-press detect with auto-repeat, and an event counter (wrap or saturate, with synchronous clear).
- Sits between the board pushbuttons and the display/control logic; the flat count bus feeds the 7-segment driver directly.

Parameters:
- NUM_CH, 3: number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 5000000: consecutive stable synchronised samples needed to accept a level change (>=1).
- HOLD_CYCLES, 100000000: cycles after press_pulse until long_pulse (>=1).
- REPEAT_CYCLES, 25000000: auto-repeat period after long press; 0 disables repeat.
- COUNT_W, 8: width of each channel's event counter.
- SATURATE, 0: 1 = counter sticks at 2^COUNT_W-1; 0 = counter wraps to 0.

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- pb_raw  in  NUM_CH  raw, asynchronous button inputs.
- clear  in  NUM_CH  synchronous per-channel counter clear.
- pb_level  out  NUM_CH  debounced level.
- press_pulse  out  NUM_CH  1-cycle pulse on accepted 0->1.
- release_pulse  out  NUM_CH  1-cycle pulse on accepted 1->0.
- long_pulse  out  NUM_CH  1-cycle pulse when hold reaches HOLD_CYCLES.
- repeat_pulse  out  NUM_CH  1-cycle auto-repeat pulses.
- counts  out  NUM_CH*COUNT_W  channel i at [i*COUNT_W +: COUNT_W].

Behaviour:
- Reset (reset=0, asynchronous): synchronisers, FSMs and counters cleared; every output 0 immediately.
- Synchroniser: 2 FFs per channel, reset to 0.
- FSM states per channel: IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW.
- IDLE_LOW: sync=1 -> WAIT_HIGH, stable counter = 1.
- WAIT_HIGH: sync=1 increments; sync=0 -> IDLE_LOW, counter cleared. On reaching DEBOUNCE_CYCLES -> HELD_HIGH, pb_level=1, press_pulse for one cycle.
- HELD_HIGH and WAIT_LOW: mirror WAIT_HIGH for sync=0. On confirm -> IDLE_LOW, pb_level=0, release_pulse for one cycle, hold counter cleared. A bounce back to 1 returns to HELD_HIGH.
- Latency: edge 0 is the first edge sampling a new raw level held stable. press_pulse/release_pulse assert in the cycle after edge DEBOUNCE_CYCLES+2. Glitches shorter than DEBOUNCE_CYCLES produce no pulse and no level change.
- Hold timing, with P = the press_pulse edge:
  - Hold counter runs only in HELD_HIGH and pauses in WAIT_LOW.
  - long_pulse at P+HOLD_CYCLES.
  - If REPEAT_CYCLES>0: repeat_pulse at P+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1, while in HELD_HIGH.
  - No long/repeat pulses in WAIT_LOW.
  - Hold counter saturates after long_pulse when repeat is disabled.
- Counter update:
  - Increments by 1 on press_pulse or repeat_pulse; long_pulse does not count.
  - clear[i] has priority over increment; count reads 0 the next cycle.
  - At 2^COUNT_W-1: SATURATE=1 holds the value, SATURATE=0 wraps to 0.
- Channels are fully independent; simultaneous events on different channels are all honoured the same cycle.
- Reset mid-press: after reset deasserts with pb_raw held 1, the channel redebounces from IDLE_LOW. press_pulse follows DEBOUNCE_CYCLES+2 edges after the first sampling edge; count becomes 1.
- Internal counter widths: $clog2 of the max value + 1. No combinational path from pb_raw to any output.

Decomposition:
- Package pb_event_pkg: state enum typedef (IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW) and the width helper function.
- Sub-module pb_event_channel: one channel (sync + FSM + hold/repeat + counter), instantiated NUM_CH times in a generate loop.
- Top handles only count bus packing.

Test Plan (NUM_CH=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, COUNT_W=4 unless noted):
- Clean press: ch0 raw=1 sampled from edge 0, low sampled from edge 12 -> press_pulse[0] after edge 6, release_pulse[0] after edge 18, pb_level[0]=1 between them, counts ch0=1.
- Bounce: ch1 raw high for 3 cycles, then low -> no pulses, pb_level[1]=0, count 0. Edges 0-2 high / 3 low / 4-20 high -> single press_pulse after edge 10.
- Long hold: ch2 raw high edges 0-44 -> press 6, long 26, repeat 34 and 42, none at 50, release after edge 51, count ch2=3.
- Wrap/saturate: 17 clean presses -> SATURATE=0 gives count 1; SATURATE=1 gives count 15.
- Clear collision: clear[0] asserted in the press_pulse[0] cycle with count=5 -> count 0 next cycle, not 1.
- Async reset: reset=0 at edge 30 during a held ch0 -> all outputs 0 before the next edge. After release with raw still 1 -> press_pulse after edge DEBOUNCE_CYCLES+2 from the first sampling edge, count 1. Simultaneous press on ch1/ch2 -> both pulse in the same cycle.
